// File: rtl/tsc_stream_decoder.sv
// ----------------------------------------------------------------------------
// tsc_stream_decoder
//
// Receive side of the three-register stream cipher. It regenerates the same
// keystream as the encoder from a shared 8-bit seed and XORs each incoming
// ciphertext byte with one keystream byte to recover the plaintext. One
// keystream byte is built from eight register shifts.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   seed_valid  in   seed byte present on seed (accepted only in IDLE)
//   seed[7:0]   in   shared seed; 8'h00 and 8'hFF are rejected
//   resync      in   one-cycle pulse: reload INIT_* values, return to IDLE
//   in_valid    in   ciphertext byte valid
//   in_data     in   ciphertext byte
//   in_ready    out  decoder can accept a ciphertext byte
//   out_valid   out  plaintext byte valid (held until out_ready)
//   out_data    out  plaintext byte
//   out_ready   in   consumer accepts out_data
//   seeded      out  keystream registers hold a loaded seed
//   byte_count  out  [15:0] delivered-byte counter, only present when the
//                    macro TSC_DEC_BYTE_COUNT_EN is defined
//
// Optional feature macro: TSC_DEC_BYTE_COUNT_EN
// ----------------------------------------------------------------------------
module tsc_stream_decoder #(
  parameter int          GEN_STEPS = 8,
  parameter logic [63:0] INIT_S1   = 64'h23A2B,
  parameter logic [63:0] INIT_S2   = 64'h2A892,
  parameter logic [63:0] INIT_S3   = 64'hF4511
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_valid,
  input  logic [7:0] seed,
  input  logic       resync,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       seeded
`ifdef TSC_DEC_BYTE_COUNT_EN
  ,
  output logic [15:0] byte_count
`endif
);

  // A keystream byte is exactly one byte wide; other step counts are invalid.
  if (GEN_STEPS != 8) begin : g_cfg_error
    $error("tsc_stream_decoder: GEN_STEPS must be 8");
  end

  localparam logic [2:0] LAST_STEP = 3'(GEN_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    GEN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Keystream output bit taken from the current register contents.
  function automatic logic ks_bit(input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] c);
    return a[0] ^ b[0] ^ c[0];
  endfunction

  // Feedback bit shifted into s1 (a=s1, b=s2, c=s3).
  function automatic logic fb_s1(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c);
    return b[0] ^ c[1] ^ a[5] ^ b[7] ^ c[13] ^ a[31] ^ b[47] ^ c[60];
  endfunction

  // Feedback bit shifted into s2.
  function automatic logic fb_s2(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c);
    return c[3] ^ a[1] ^ b[2] ^ c[19] ^ a[23];
  endfunction

  // Feedback bit shifted into s3.
  function automatic logic fb_s3(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c);
    return a[5] ^ b[2] ^ c[4] ^ a[17] ^ b[29] ^ c[63] ^ a[10] ^ b[40];
  endfunction

  state_t      state_r, state_nxt;
  logic [63:0] s1_r, s1_nxt;
  logic [63:0] s2_r, s2_nxt;
  logic [63:0] s3_r, s3_nxt;
  logic [7:0]  ks_r, ks_nxt;
  logic [2:0]  step_r, step_nxt;
  logic [7:0]  cbuf_r, cbuf_nxt;
  logic        in_ready_r, in_ready_nxt;
  logic        out_valid_r, out_valid_nxt;
  logic [7:0]  out_data_r, out_data_nxt;
  logic        seeded_r, seeded_nxt;
  logic        seed_legal;
  logic        new_bit;

  assign seed_legal = (seed != 8'h00) && (seed != 8'hFF);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign seeded    = seeded_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state, keystream datapath and next output values.
  always_comb begin
    state_nxt     = state_r;
    s1_nxt        = s1_r;
    s2_nxt        = s2_r;
    s3_nxt        = s3_r;
    ks_nxt        = ks_r;
    step_nxt      = step_r;
    cbuf_nxt      = cbuf_r;
    out_valid_nxt = out_valid_r;
    out_data_nxt  = out_data_r;
    seeded_nxt    = seeded_r;
    new_bit       = ks_bit(s1_r, s2_r, s3_r);

    if (resync) begin
      // Resync wins over any handshake in the same cycle; an in-flight
      // byte is simply discarded.
      state_nxt     = IDLE;
      s1_nxt        = INIT_S1;
      s2_nxt        = INIT_S2;
      s3_nxt        = INIT_S3;
      ks_nxt        = 8'd0;
      step_nxt      = 3'd0;
      out_valid_nxt = 1'b0;
      out_data_nxt  = 8'd0;
      seeded_nxt    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (seed_valid && seed_legal) begin
            s1_nxt     = {48'd0, seed, seed};
            s2_nxt     = {48'd0, seed, ~seed[3:0], seed[7:4]};
            s3_nxt     = {48'd0, seed, seed ^ 8'hA5};
            seeded_nxt = 1'b1;
            state_nxt  = READY;
          end else begin
            state_nxt = IDLE;
          end
        end
        READY: begin
          if (in_valid && in_ready_r) begin
            cbuf_nxt  = in_data;
            ks_nxt    = 8'd0;
            step_nxt  = 3'd0;
            state_nxt = GEN;
          end else begin
            state_nxt = READY;
          end
        end
        GEN: begin
          // Registers keep running across bytes; they are never rewound.
          ks_nxt   = {ks_r[6:0], new_bit};
          s1_nxt   = {s1_r[62:0], fb_s1(s1_r, s2_r, s3_r)};
          s2_nxt   = {s2_r[62:0], fb_s2(s1_r, s2_r, s3_r)};
          s3_nxt   = {s3_r[62:0], fb_s3(s1_r, s2_r, s3_r)};
          step_nxt = step_r + 3'd1;
          if (step_r == LAST_STEP) begin
            // ks_r only holds seven bits so far; append this cycle's bit.
            out_data_nxt  = cbuf_r ^ {ks_r[6:0], new_bit};
            out_valid_nxt = 1'b1;
            state_nxt     = HOLD;
          end else begin
            state_nxt = GEN;
          end
        end
        HOLD: begin
          if (out_valid_r && out_ready) begin
            out_valid_nxt = 1'b0;
            state_nxt     = READY;
          end else begin
            state_nxt = HOLD;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    in_ready_nxt = (state_nxt == READY);
  end

  // Keystream registers, byte buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r        <= INIT_S1;
      s2_r        <= INIT_S2;
      s3_r        <= INIT_S3;
      ks_r        <= 8'd0;
      step_r      <= 3'd0;
      cbuf_r      <= 8'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
      seeded_r    <= 1'b0;
    end else begin
      s1_r        <= s1_nxt;
      s2_r        <= s2_nxt;
      s3_r        <= s3_nxt;
      ks_r        <= ks_nxt;
      step_r      <= step_nxt;
      cbuf_r      <= cbuf_nxt;
      in_ready_r  <= in_ready_nxt;
      out_valid_r <= out_valid_nxt;
      out_data_r  <= out_data_nxt;
      seeded_r    <= seeded_nxt;
    end
  end

`ifdef TSC_DEC_BYTE_COUNT_EN
  logic [15:0] byte_count_r;

  assign byte_count = byte_count_r;

  // Delivered-byte counter; restarts on resync and on every seed load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count_r <= 16'd0;
    end else if (resync) begin
      byte_count_r <= 16'd0;
    end else if ((state_r == IDLE) && seed_valid && seed_legal) begin
      byte_count_r <= 16'd0;
    end else if ((state_r == HOLD) && out_valid_r && out_ready) begin
      byte_count_r <= byte_count_r + 16'd1;
    end else begin
      byte_count_r <= byte_count_r;
    end
  end
`endif

endmodule

// File: tb/tb_tsc_stream_decoder.sv
// ----------------------------------------------------------------------------
// tb_tsc_stream_decoder
//
// Self-checking bench for tsc_stream_decoder. A reference cipher model
// encrypts plaintext; the ciphertext is fed to the decoder and the expected
// plaintext plus accept cycle go into a scoreboard queue, checked by a
// monitor for data and 8-cycle latency when the decoder delivers.
// ----------------------------------------------------------------------------
module tb_tsc_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_valid;
  logic [7:0]  seed;
  logic        resync;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        seeded;
`ifdef TSC_DEC_BYTE_COUNT_EN
  logic [15:0] byte_count;
`endif

  tsc_stream_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .resync     (resync),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .seeded     (seeded)
`ifdef TSC_DEC_BYTE_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference cipher state.
  logic [63:0] m1, m2, m3;
  logic [7:0]  cur_pt;

  typedef struct {
    logic [7:0] pt;
    int         acc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [7:0] seed;
    logic       exp_seeded;
  } seed_vec_t;

  typedef struct {
    logic       new_seed;
    logic [7:0] seed;
    logic [7:0] pt;
    int         stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_seed(input logic [7:0] sd);
    m1 = {48'd0, sd, sd};
    m2 = {48'd0, sd, ~sd[3:0], sd[7:4]};
    m3 = {48'd0, sd, sd ^ 8'hA5};
  endtask

  // Encrypt one byte with the reference cipher, advancing its state.
  task automatic model_byte(input logic [7:0] pt, output logic [7:0] ct);
    logic [63:0] x, y, z;
    logic [7:0]  k;
    logic        b0, f1, f2, f3;
    x = m1; y = m2; z = m3; k = 8'd0;
    for (int i = 0; i < 8; i++) begin
      b0 = x[0] ^ y[0] ^ z[0];
      f1 = y[0] ^ z[1] ^ x[5] ^ y[7] ^ z[13] ^ x[31] ^ y[47] ^ z[60];
      f2 = z[3] ^ x[1] ^ y[2] ^ z[19] ^ x[23];
      f3 = x[5] ^ y[2] ^ z[4] ^ x[17] ^ y[29] ^ z[63] ^ x[10] ^ y[40];
      x = {x[62:0], f1};
      y = {y[62:0], f2};
      z = {z[62:0], f3};
      k = {k[6:0], b0};
    end
    m1 = x; m2 = y; m3 = z;
    ct = pt ^ k;
  endtask

  // Wait for in_ready and hand over the encrypted byte; returns after the accept edge.
  task automatic drive_accept(input logic [7:0] pt);
    logic [7:0] ct;
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    model_byte(pt, ct);
    cur_pt   = pt;
    in_data  = ct;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Full byte transfer, optionally holding out_ready low for 'stall' cycles.
  task automatic send_byte(input logic [7:0] pt, input int stall);
    logic [7:0] held;
    logic       stable;
    int n;
    if (stall > 0) out_ready = 1'b0;
    drive_accept(pt);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
    if (stall > 0) begin
      held   = out_data;
      stable = 1'b1;
      repeat (stall) begin
        tick();
        if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      end
      chk("stall_stable", {31'd0, stable}, 32'd1);
      out_ready = 1'b1;
    end
    tick();
  endtask

  task automatic reseed(input logic [7:0] sd);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    seed_valid = 1'b1;
    seed = sd;
    tick();
    seed_valid = 1'b0;
    model_seed(sd);
    chk("seeded_after_load", {31'd0, seeded}, 32'd1);
  endtask

  // Cycle counter: number of rising edges so far.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Scoreboard monitor, sampling mid-cycle.
  initial begin
    sb_t e;
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (in_valid && in_ready) begin
          e.pt  = cur_pt;
          e.acc = cyc + 1;
          sb.push_back(e);
        end
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
          else chk("latency", cyc - sb[0].acc, 32'd8);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("out_data", {24'd0, out_data}, {24'd0, e.pt});
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  seed_vec_t stab[3];
  vec_t      vtab[8];

  initial begin
    int ov_seen;

    stab[0] = '{8'h00, 1'b0};
    stab[1] = '{8'hFF, 1'b0};
    stab[2] = '{8'h3C, 1'b1};

    vtab[0] = '{1'b1, 8'h5A, 8'h41, 0};
    vtab[1] = '{1'b0, 8'h5A, 8'h42, 0};
    vtab[2] = '{1'b0, 8'h5A, 8'h43, 0};
    vtab[3] = '{1'b1, 8'h3C, 8'h00, 0};
    vtab[4] = '{1'b0, 8'h3C, 8'hFF, 20};
    vtab[5] = '{1'b0, 8'h3C, 8'hA5, 0};
    vtab[6] = '{1'b1, 8'h81, 8'h7E, 3};
    vtab[7] = '{1'b0, 8'h81, 8'h01, 0};

    rst = 1'b1; seed_valid = 1'b0; seed = 8'h00; resync = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; cur_pt = 8'h00;
    m1 = 64'd0; m2 = 64'd0; m3 = 64'd0;

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_seeded", {31'd0, seeded}, 32'd0);
    rst = 1'b0;
    tick();

    // Illegal then legal seeds
    for (int i = 0; i < 3; i++) begin
      seed_valid = 1'b1;
      seed = stab[i].seed;
      tick();
      seed_valid = 1'b0;
      chk("seed_seeded", {31'd0, seeded}, {31'd0, stab[i].exp_seeded});
      chk("seed_in_ready", {31'd0, in_ready}, {31'd0, stab[i].exp_seeded});
    end
    chk("seed_s1_low", {16'd0, dut.s1_r[15:0]}, 32'h3C3C);
    chk("seed_s3_low", {16'd0, dut.s3_r[15:0]}, 32'h3C99);

    // Table-driven round trips
    for (int i = 0; i < 8; i++) begin
      if (vtab[i].new_seed) reseed(vtab[i].seed);
      send_byte(vtab[i].pt, vtab[i].stall);
`ifdef TSC_DEC_BYTE_COUNT_EN
      if (i == 2) chk("byte_count_3", {16'd0, byte_count}, 32'd3);
`endif
    end

    // Resync during GEN step 4
    reseed(8'h5A);
    send_byte(8'h41, 0);
    drive_accept(8'h42);
    repeat (4) tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    sb.delete();
    ov_seen = 0;
    repeat (15) begin
      tick();
      if (out_valid) ov_seen++;
    end
    chk("resync_no_out", ov_seen, 32'd0);
    chk("resync_seeded", {31'd0, seeded}, 32'd0);
    chk("resync_in_ready", {31'd0, in_ready}, 32'd0);
    chk("resync_out_data", {24'd0, out_data}, 32'd0);
`ifdef TSC_DEC_BYTE_COUNT_EN
    chk("byte_count_resync", {16'd0, byte_count}, 32'd0);
`endif

    // Resync in IDLE beats a simultaneous seed
    resync = 1'b1; seed_valid = 1'b1; seed = 8'h5A;
    tick();
    resync = 1'b0; seed_valid = 1'b0;
    chk("idle_resync_beats_seed", {31'd0, seeded}, 32'd0);

    // Fresh stream after resync
    seed_valid = 1'b1; seed = 8'h5A;
    tick();
    seed_valid = 1'b0;
    model_seed(8'h5A);
    chk("reseed_seeded", {31'd0, seeded}, 32'd1);
    send_byte(8'h41, 0);
    send_byte(8'h42, 0);

    // Asynchronous reset while holding a result
    out_ready = 1'b0;
    drive_accept(8'h99);
    ov_seen = 0;
    while (!out_valid && ov_seen < 20) begin
      tick();
      ov_seen++;
    end
    chk("hold_reached", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_seeded", {31'd0, seeded}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // Decoding restarts cleanly after reset
    seed_valid = 1'b1; seed = 8'h3C;
    tick();
    seed_valid = 1'b0;
    model_seed(8'h3C);
    send_byte(8'hC3, 0);
    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
